// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bundle: hazard/redirect inputs, ROM port, IF/ID register and counters
interface inst_fetch_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic [31:0]      inst_in;
    logic [31:0]      pc_out;
    logic [31:0]      id_inst;
    logic [31:0]      id_pc4;
    logic             id_valid;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output stall, branch_taken, branch_target, inst_in,
        input  pc_out, id_inst, id_pc4, id_valid, fetch_cnt, stall_cnt
    );

    modport slave (
        input  stall, branch_taken, branch_target, inst_in,
        output pc_out, id_inst, id_pc4, id_valid, fetch_cnt, stall_cnt
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with PC, IF/ID register and saturating performance counters
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    inst_fetch_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        scnt_d  = scnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            default: begin
                // Redirect wins over stall so a flushed load-use hold costs no stall cycle.
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_target & 32'hFFFF_FFFC;
                    inst_d  = NOP_WORD;
                    pc4_d   = 32'd0;
                    valid_d = 1'b0;
                    state_d = RUN;
                end else if (bus.stall) begin
                    if (scnt_q != '1) scnt_d = scnt_q + CNT_ONE;
                    state_d = HOLD;
                end else begin
                    pc_d    = pc_plus4;
                    inst_d  = bus.inst_in;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    if (fcnt_q != '1) fcnt_d = fcnt_q + CNT_ONE;
                    state_d = RUN;
                end
            end
        endcase
    end

    assign bus.pc_out    = pc_q;
    assign bus.id_inst   = inst_q;
    assign bus.id_pc4    = pc4_q;
    assign bus.id_valid  = valid_q;
    assign bus.fetch_cnt = fcnt_q;
    assign bus.stall_cnt = scnt_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed checks of inst_fetch at CNT_W=16 and CNT_W=4 sharing one stimulus
module tb_inst_fetch;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    int          checks;
    int          errors;

    inst_fetch_if #(.CNT_W(16)) bw ();
    inst_fetch_if #(.CNT_W(4))  sw ();

    inst_fetch #(.CNT_W(16)) u_big (.clk(clk), .rst(rst), .bus(bw));
    inst_fetch #(.CNT_W(4))  u_sml (.clk(clk), .rst(rst), .bus(sw));

    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0:   rom = 32'h0000_0000;
            32'h4:   rom = 32'h0010_0443;
            32'h8:   rom = 32'h0010_0421;
            32'hC:   rom = 32'h0420_18E1;
            default: rom = {addr[15:0], 16'hBEEF};
        endcase
    endfunction

    assign bw.stall         = stall;
    assign bw.branch_taken  = branch_taken;
    assign bw.branch_target = branch_target;
    assign bw.inst_in       = rom(bw.pc_out);
    assign sw.stall         = stall;
    assign sw.branch_taken  = branch_taken;
    assign sw.branch_target = branch_target;
    assign sw.inst_in       = rom(sw.pc_out);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"},   bw.pc_out, 32'h0);
        check({tag, "_inst"}, bw.id_inst, 32'h0);
        check({tag, "_pc4"},  bw.id_pc4, 32'h0);
        check({tag, "_vld"},  {31'd0, bw.id_valid}, 32'h0);
        check({tag, "_fc"},   {16'd0, bw.fetch_cnt}, 32'h0);
        check({tag, "_sc"},   {16'd0, bw.stall_cnt}, 32'h0);
        check({tag, "_sfc"},  {28'd0, sw.fetch_cnt}, 32'h0);
        check({tag, "_ssc"},  {28'd0, sw.stall_cnt}, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        step();
        step();
        check_reset("rst");

        rst = 1'b0;
        step();
        check("boot_pc", bw.pc_out, 32'h0);
        check("boot_vld", {31'd0, bw.id_valid}, 32'h0);
        step();
        check("f0_vld", {31'd0, bw.id_valid}, 32'h1);
        check("f0_inst", bw.id_inst, 32'h0);
        check("f0_pc4", bw.id_pc4, 32'h4);
        check("f0_pc", bw.pc_out, 32'h4);
        check("f0_fc", {16'd0, bw.fetch_cnt}, 32'd1);
        step();
        check("f1_inst", bw.id_inst, 32'h0010_0443);
        check("f1_pc4", bw.id_pc4, 32'h8);
        step();
        check("f2_inst", bw.id_inst, 32'h0010_0421);
        check("f2_pc4", bw.id_pc4, 32'hC);
        check("f2_pc", bw.pc_out, 32'hC);

        stall = 1'b1;
        step();
        check("st1_pc", bw.pc_out, 32'hC);
        check("st1_inst", bw.id_inst, 32'h0010_0421);
        check("st1_sc", {16'd0, bw.stall_cnt}, 32'd1);
        step();
        check("st2_pc", bw.pc_out, 32'hC);
        check("st2_inst", bw.id_inst, 32'h0010_0421);
        check("st2_sc", {16'd0, bw.stall_cnt}, 32'd2);
        check("st2_fc", {16'd0, bw.fetch_cnt}, 32'd3);
        stall = 1'b0;
        step();
        check("f3_pc", bw.pc_out, 32'h10);
        check("f3_inst", bw.id_inst, 32'h0420_18E1);
        check("f3_pc4", bw.id_pc4, 32'h10);
        check("f3_fc", {16'd0, bw.fetch_cnt}, 32'd4);

        branch_taken = 1'b1;
        stall = 1'b1;
        branch_target = 32'h23;
        step();
        check("br_pc", bw.pc_out, 32'h20);
        check("br_vld", {31'd0, bw.id_valid}, 32'h0);
        check("br_inst", bw.id_inst, 32'h0);
        check("br_pc4", bw.id_pc4, 32'h0);
        check("br_sc", {16'd0, bw.stall_cnt}, 32'd2);
        check("br_ssc", {28'd0, sw.stall_cnt}, 32'd2);

        stall = 1'b0;
        branch_target = 32'hFFFF_FFFF;
        step();
        check("wbr_pc", bw.pc_out, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        step();
        check("wrap_pc", bw.pc_out, 32'h0);
        check("wrap_pc4", bw.id_pc4, 32'h0);
        check("wrap_inst", bw.id_inst, 32'hFFFC_BEEF);
        check("wrap_vld", {31'd0, bw.id_valid}, 32'h1);
        check("wrap_fc", {16'd0, bw.fetch_cnt}, 32'd5);

        for (int i = 0; i < 20; i++) step();
        check("sat_sfc", {28'd0, sw.fetch_cnt}, 32'hF);
        check("sat_fc", {16'd0, bw.fetch_cnt}, 32'd25);
        check("sat_pc", bw.pc_out, 32'h50);
        check("sat_inst", bw.id_inst, 32'h004C_BEEF);
        check("sat_spc", sw.pc_out, 32'h50);

        stall = 1'b1;
        step();
        check("hold_ssc", {28'd0, sw.stall_cnt}, 32'd3);
        rst = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        step();
        check_reset("mrst");
        check("mrst_spc", sw.pc_out, 32'h0);

        rst = 1'b0;
        step();
        check("boot2_pc", bw.pc_out, 32'h0);
        check("boot2_sc", {16'd0, bw.stall_cnt}, 32'd0);
        check("boot2_vld", {31'd0, bw.id_valid}, 32'h0);
        branch_taken = 1'b0;
        step();
        check("h2_sc", {16'd0, bw.stall_cnt}, 32'd1);
        check("h2_pc", bw.pc_out, 32'h0);
        stall = 1'b0;
        step();
        check("r2_pc", bw.pc_out, 32'h4);
        check("r2_vld", {31'd0, bw.id_valid}, 32'h1);
        check("r2_fc", {16'd0, bw.fetch_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
